dili_ntt_ctrl: RTL and testbench

Sequencer for the Dilithium NTT/INTT over a 256-coefficient polynomial held in a dual-read/dual-write coefficient RAM, driving a single pipelined `dili_ntt_bu` butterfly. It walks all 8 layers, issuing one butterfly per cycle with even/odd addresses and the zeta table index. It delays the addresses to line up with butterfly write-back. In inverse mode it also sequences the final Montgomery scaling pass. It sits between the polynomial-arithmetic top-level FSM (start/done) and the RAM/zeta-ROM/butterfly datapath.

---
 rtl/dili_ntt_ctrl_if.sv | 33 +++
 rtl/dili_ntt_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dili_ntt_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dili_ntt_ctrl_if.sv
// Control and address bundle between the polynomial FSM, the NTT sequencer and
// the coefficient-RAM / zeta-ROM / butterfly datapath.
interface dili_ntt_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start_i;
  logic              inv_i;
  logic              stall_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_even_o;
  logic [ADDR_W-1:0] rd_addr_odd_o;
  logic [7:0]        zeta_idx_o;
  logic              zeta_neg_o;
  logic              scale_o;
  logic [2:0]        layer_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_even_o;
  logic [ADDR_W-1:0] wr_addr_odd_o;

  modport master (
    input  start_i, inv_i, stall_i,
    output busy_o, done_o, rd_en_o, rd_addr_even_o, rd_addr_odd_o, zeta_idx_o,
           zeta_neg_o, scale_o, layer_o, wr_en_o, wr_addr_even_o, wr_addr_odd_o
  );

  modport slave (
    output start_i, inv_i, stall_i,
    input  busy_o, done_o, rd_en_o, rd_addr_even_o, rd_addr_odd_o, zeta_idx_o,
           zeta_neg_o, scale_o, layer_o, wr_en_o, wr_addr_even_o, wr_addr_odd_o
  );
endinterface

// File: rtl/dili_ntt_ctrl.sv
// Dilithium NTT/INTT sequencer: walks 8 butterfly layers (plus the INTT scaling
// pass), one issue per cycle, and delays addresses to butterfly write-back.
module dili_ntt_ctrl #(
  parameter int N      = 256,
  parameter int ADDR_W = 8,
  parameter int BU_LAT = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  dili_ntt_ctrl_if.master bus
);
  localparam int HALF  = N / 2;
  localparam int CNT_W = $clog2(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  typedef enum logic [1:0] {IDLE, LAYER, SCALE, DRAIN} state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] even;
    logic [ADDR_W-1:0] odd;
  } wb_t;

  state_e            state_q, state_d;
  logic              inv_q, inv_d;
  logic [2:0]        lyr_q, lyr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] even_q, even_d;
  logic [ADDR_W-1:0] odd_q, odd_d;
  logic [7:0]        zeta_q, zeta_d;
  logic              neg_q, neg_d;
  logic              scale_q, scale_d;
  logic [2:0]        layer_q, layer_d;
  wb_t               wb_q [BU_LAT];
  wb_t               wb_d [BU_LAT];
  logic              wb_tail_empty;

  logic [2:0]        sh;
  logic [ADDR_W-1:0] len, grp, off, base;

  // Everything except the final stage is empty: after this edge no write is pending.
  always_comb begin
    wb_tail_empty = 1'b1;
    for (int k = 0; k < BU_LAT - 1; k++) begin
      if (wb_q[k].valid) wb_tail_empty = 1'b0;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    inv_d   = inv_q;
    lyr_d   = lyr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wb_d    = wb_q;
    if (!bus.stall_i) begin
      done_d  = 1'b0;
      wb_d[0] = '{valid: rd_en_q, even: even_q, odd: odd_q};
      for (int k = 1; k < BU_LAT; k++) wb_d[k] = wb_q[k-1];
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_d = LAYER;
            inv_d   = bus.inv_i;
            lyr_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        LAYER: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            if (lyr_q == 3'd7) state_d = inv_q ? SCALE : DRAIN;
            else               lyr_d   = lyr_q + 3'd1;
          end
        end
        SCALE: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = DRAIN;
        end
        DRAIN: begin
          // done is held in DRAIN for its cycle so a start there is still ignored.
          if (done_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else if (wb_tail_empty) begin
            done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Issue fields are decoded from the next counters so the outputs come straight from flops.
  always_comb begin
    sh   = inv_d ? lyr_d : 3'd7 - lyr_d;
    len  = ADDR_W'(1) << sh;
    grp  = ADDR_W'(cnt_d) >> sh;
    off  = ADDR_W'(cnt_d) & (len - 1'b1);
    base = ((grp << sh) << 1) | off;

    rd_en_d  = 1'b0;
    even_d   = '0;
    odd_d    = '0;
    zeta_d   = '0;
    neg_d    = 1'b0;
    scale_d  = 1'b0;
    layer_d  = '0;
    case (state_d)
      LAYER: begin
        rd_en_d = 1'b1;
        even_d  = base;
        odd_d   = base + len;
        zeta_d  = inv_d ? (8'hFF >> lyr_d) - 8'(grp) : (8'd1 << lyr_d) + 8'(grp);
        neg_d   = inv_d;
        layer_d = lyr_d;
      end
      SCALE: begin
        rd_en_d = 1'b1;
        even_d  = ADDR_W'(cnt_d);
        odd_d   = ADDR_W'(cnt_d) + ADDR_W'(HALF);
        neg_d   = inv_d;
        scale_d = 1'b1;
        layer_d = lyr_d;
      end
      DRAIN:   neg_d = inv_d;
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
      lyr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      even_q  <= '0;
      odd_q   <= '0;
      zeta_q  <= '0;
      neg_q   <= 1'b0;
      scale_q <= 1'b0;
      layer_q <= '0;
      // NOTE: the write-back line is a handful of flops, not a RAM, so it is reset with the rest.
      for (int k = 0; k < BU_LAT; k++) wb_q[k] <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      lyr_q   <= lyr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      zeta_q  <= zeta_d;
      neg_q   <= neg_d;
      scale_q <= scale_d;
      layer_q <= layer_d;
      wb_q    <= wb_d;
    end
  end

  // The strobes are masked by stall in the same cycle; a strobe is only consumed when stall_i is low.
  assign bus.rd_en_o        = rd_en_q & ~bus.stall_i;
  assign bus.wr_en_o        = wb_q[BU_LAT-1].valid & ~bus.stall_i;
  assign bus.wr_addr_even_o = wb_q[BU_LAT-1].even;
  assign bus.wr_addr_odd_o  = wb_q[BU_LAT-1].odd;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.rd_addr_even_o = even_q;
  assign bus.rd_addr_odd_o  = odd_q;
  assign bus.zeta_idx_o     = zeta_q;
  assign bus.zeta_neg_o     = neg_q;
  assign bus.scale_o        = scale_q;
  assign bus.layer_o        = layer_q;
endmodule

// File: tb/tb_dili_ntt_ctrl.sv
// Directed bench for dili_ntt_ctrl: a loop-order reference model fills an issue
// scoreboard; a monitor checks issues, write-back timing/addresses and done.
`timescale 1ns/1ps
module tb_dili_ntt_ctrl;
  localparam int ADDR_W = 8;
  localparam int BU_LAT = 3;

  typedef struct packed {
    logic [7:0] ev;
    logic [7:0] od;
    logic [7:0] zeta;
    logic       neg;
    logic       scale;
    logic [2:0] layer;
  } iss_t;

  typedef struct {
    int         due;
    logic [3:0] grp;   // layer 0..7, or 8 for the scale pass
    logic [7:0] ev;
    logic [7:0] od;
  } wr_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dili_ntt_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  dili_ntt_ctrl #(.N(256), .ADDR_W(ADDR_W), .BU_LAT(BU_LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0  = 0;
  int act = 0;
  always @(posedge clk) cyc++;

  int      n_checks = 0;
  int      n_pass   = 0;
  iss_t    iss_q[$];
  wr_exp_t wr_q[$];
  iss_t    obs_iss [0:1151];
  int      n_obs;
  int      wr_hits [0:8][0:255];
  int      n_done, done_rel;
  logic    done_busy;
  bit      mon_en = 1'b0;
  iss_t    got_iss, exp_iss;
  wr_exp_t we;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.busy_o, bus.done_o, bus.rd_en_o, bus.rd_addr_even_o, bus.rd_addr_odd_o,
                bus.zeta_idx_o, bus.zeta_neg_o, bus.scale_o, bus.layer_o, bus.wr_en_o,
                bus.wr_addr_even_o, bus.wr_addr_odd_o});
  endfunction

  function automatic iss_t mk(input int ev, input int od, input int z,
                              input logic neg, input logic sc, input int ly);
    return {8'(ev), 8'(od), 8'(z), neg, sc, 3'(ly)};
  endfunction

  // Reference in the textbook loop order: zeta index is ++k (NTT) or --k from 256 (INTT).
  task automatic push_model(input logic inv);
    int k, len;
    iss_t e;
    k = inv ? 256 : 0;
    for (int l = 0; l < 8; l++) begin
      len = inv ? (1 << l) : (128 >> l);
      for (int st = 0; st < 256; st += 2 * len) begin
        if (inv) k--; else k++;
        for (int j = st; j < st + len; j++) begin
          e = mk(j, j + len, k, inv, 1'b0, l);
          iss_q.push_back(e);
        end
      end
    end
    if (inv) begin
      for (int c = 0; c < 128; c++) begin
        e = mk(c, c + 128, 0, 1'b1, 1'b1, 7);
        iss_q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.stall_i) begin
        check("stall_rd_en", 64'(bus.rd_en_o), 64'(0));
        check("stall_wr_en", 64'(bus.wr_en_o), 64'(0));
      end
      if (bus.rd_en_o) begin
        got_iss = {bus.rd_addr_even_o, bus.rd_addr_odd_o, bus.zeta_idx_o,
                   bus.zeta_neg_o, bus.scale_o, bus.layer_o};
        if (n_obs < 1152) obs_iss[n_obs] = got_iss;
        n_obs++;
        check("issue_expected", 64'(iss_q.size() > 0), 64'(1));
        if (iss_q.size() > 0) begin
          exp_iss = iss_q.pop_front();
          check($sformatf("issue%0d", n_obs), 64'(got_iss), 64'(exp_iss));
          we.due = act + BU_LAT;
          we.grp = exp_iss.scale ? 4'd8 : {1'b0, exp_iss.layer};
          we.ev  = exp_iss.ev;
          we.od  = exp_iss.od;
          wr_q.push_back(we);
        end
      end
      if (bus.wr_en_o) begin
        check("write_expected", 64'(wr_q.size() > 0), 64'(1));
        if (wr_q.size() > 0) begin
          we = wr_q.pop_front();
          check("wr_time", 64'(act), 64'(we.due));
          check("wr_addr", 64'({bus.wr_addr_even_o, bus.wr_addr_odd_o}), 64'({we.ev, we.od}));
          wr_hits[we.grp][bus.wr_addr_even_o]++;
          wr_hits[we.grp][bus.wr_addr_odd_o]++;
        end
      end
      if (bus.done_o) begin
        n_done++;
        done_rel  = cyc - t0;
        done_busy = bus.busy_o;
      end
      if (!bus.stall_i) act++;
    end
  end

  task automatic goto_cycle(input int rel);
    do begin
      @(posedge clk);
      #1;
    end while (cyc - t0 < rel);
  endtask

  task automatic start_run(input logic inv);
    iss_q.delete();
    wr_q.delete();
    n_obs    = 0;
    n_done   = 0;
    done_rel = -1;
    for (int g = 0; g < 9; g++)
      for (int a = 0; a < 256; a++) wr_hits[g][a] = 0;
    push_model(inv);
    @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.inv_i   = inv;
    t0 = cyc;
    @(negedge clk);
    check("busy_cycle0", 64'(bus.busy_o), 64'(0));
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.inv_i   = 1'b0;
    @(negedge clk);
    check("busy_cycle1", 64'(bus.busy_o), 64'(1));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (n_done == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 64'(n_done), 64'(1));
  endtask

  task automatic finish_run(input string name, input logic inv, input int exp_done);
    int bad;
    check({name, "_done_cycle"}, 64'(done_rel), 64'(exp_done));
    check({name, "_busy_at_done"}, 64'(done_busy), 64'(1));
    check({name, "_issues_left"}, 64'(iss_q.size()), 64'(0));
    check({name, "_writes_left"}, 64'(wr_q.size()), 64'(0));
    @(negedge clk);
    check({name, "_busy_after_done"}, 64'(bus.busy_o), 64'(0));
    check({name, "_done_one_cycle"}, 64'(bus.done_o), 64'(0));
    for (int g = 0; g < (inv ? 9 : 8); g++) begin
      bad = 0;
      for (int a = 0; a < 256; a++) if (wr_hits[g][a] != 1) bad++;
      check($sformatf("%s_pass%0d_written_once", name, g), 64'(bad), 64'(0));
    end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.inv_i   = 1'b0;
    bus.stall_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outs(), 64'(0));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outs(), 64'(0));

    // NTT sweep; a start with inv=1 at cycle 500 must be ignored
    start_run(1'b0);
    goto_cycle(500);
    bus.start_i = 1'b1;
    bus.inv_i   = 1'b1;
    goto_cycle(501);
    bus.start_i = 1'b0;
    bus.inv_i   = 1'b0;
    wait_done(1300);
    finish_run("ntt", 1'b0, 1028);
    check("ntt_issue_count", 64'(n_obs), 64'(1024));
    check("ntt_issue1",    64'(obs_iss[0]),    64'(mk(0, 128, 1, 0, 0, 0)));
    check("ntt_issue129",  64'(obs_iss[128]),  64'(mk(0, 64, 2, 0, 0, 1)));
    check("ntt_issue193",  64'(obs_iss[192]),  64'(mk(128, 192, 3, 0, 0, 1)));
    check("ntt_issue1024", 64'(obs_iss[1023]), 64'(mk(254, 255, 255, 0, 0, 7)));
    check("ntt_idle_outputs", all_outs(), 64'(0));

    // INTT sweep with scaling pass
    start_run(1'b1);
    wait_done(1400);
    finish_run("intt", 1'b1, 1156);
    check("intt_issue_count", 64'(n_obs), 64'(1152));
    check("intt_issue1",   64'(obs_iss[0]),    64'(mk(0, 1, 255, 1, 0, 0)));
    check("intt_l7_c0",    64'(obs_iss[896]),  64'(mk(0, 128, 1, 1, 0, 7)));
    check("intt_scale_c5", 64'(obs_iss[1029]), 64'(mk(5, 133, 0, 1, 1, 7)));
    check("intt_idle_outputs", all_outs(), 64'(0));

    // Stall 5 cycles at issue 300 and 2 cycles in DRAIN
    start_run(1'b0);
    goto_cycle(300);
    bus.stall_i = 1'b1;
    goto_cycle(305);
    bus.stall_i = 1'b0;
    goto_cycle(1030);
    bus.stall_i = 1'b1;
    goto_cycle(1032);
    bus.stall_i = 1'b0;
    wait_done(1300);
    finish_run("stall", 1'b0, 1035);

    // Reset in mid-transform: outputs clear at once and the run never completes
    start_run(1'b0);
    goto_cycle(600);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_outputs_in_reset", all_outs(), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_outputs_after_release", all_outs(), 64'(0));
    repeat (500) @(posedge clk);
    check("abort_no_done", 64'(n_done), 64'(0));
    check("abort_not_busy", 64'(bus.busy_o), 64'(0));

    // Clean NTT after the aborted run
    start_run(1'b0);
    wait_done(1300);
    finish_run("post_reset", 1'b0, 1028);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
